// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_t;

  // Expands a per-byte enable into a per-bit mask.
  function automatic logic [31:0] mask_to_bits(logic [BYTES_PER_WORD-1:0] mask);
    logic [31:0] bits;
    bits = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      bits[8*b +: 8] = {8{mask[b]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channel between the core and the data memory.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [31:0]               req_addr;
  logic [31:0]               req_wdata;
  logic [BYTES_PER_WORD-1:0] req_bytemask;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [31:0]               rsp_rdata;
  logic                      rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_bytemask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_bytemask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_byte_merge.sv
// Combinational byte-lane merge of a new word into an old one under a byte mask.
module dmem_responder_byte_merge
  import dmem_responder_pkg::*;
(
  input  logic [31:0]               old_word_i,
  input  logic [31:0]               new_word_i,
  input  logic [BYTES_PER_WORD-1:0] byte_mask_i,
  output logic [31:0]               merged_o
);

  logic [31:0] bit_mask;

  always_comb begin
    bit_mask = mask_to_bits(byte_mask_i);
    merged_o = (old_word_i & ~bit_mask) | (new_word_i & bit_mask);
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states and
// byte-masked stores into a word-wide RAM.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned IdxW      = $clog2(DEPTH);
  localparam logic [32:0] SpanBytes = 33'(DEPTH) * 33'(BYTES_PER_WORD);
  localparam bit          NoWait    = (LATENCY == 0);
  localparam logic [3:0]  CntInit   = NoWait ? 4'd0 : 4'(LATENCY - 1);

  dmem_state_t               state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [BYTES_PER_WORD-1:0] mask_q, mask_d;
  logic                      in_range_q, in_range_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic                      accept;
  logic                      commit;
  logic                      mem_we;
  logic [31:0]               req_off;
  logic                      req_in_range;
  logic                      cur_we;
  logic                      cur_in_range;
  logic [IdxW-1:0]           cur_idx;
  logic [31:0]               cur_wdata;
  logic [BYTES_PER_WORD-1:0] cur_mask;
  logic [31:0]               old_word;
  logic [31:0]               merged_word;

  // Offset wraps for addresses below the base, so they fail the range check.
  assign req_off      = bus.req_addr - BASE_ADDR;
  assign req_in_range = {1'b0, req_off} < SpanBytes;

  assign bus.req_ready = (state_q == StIdle) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // With no wait states the commit happens on the accept edge, straight from the bus.
  always_comb begin
    if (state_q == StIdle) begin
      cur_we       = bus.req_we;
      cur_in_range = req_in_range;
      cur_idx      = req_off[IdxW+1:2];
      cur_wdata    = bus.req_wdata;
      cur_mask     = bus.req_bytemask;
    end else begin
      cur_we       = we_q;
      cur_in_range = in_range_q;
      cur_idx      = idx_q;
      cur_wdata    = wdata_q;
      cur_mask     = mask_q;
    end
  end

  assign commit = ((state_q == StWait) && (cnt_q == 4'd0)) ||
                  ((state_q == StIdle) && accept && NoWait);
  assign old_word = mem[cur_idx];
  assign mem_we   = commit && cur_we && cur_in_range && !reset;

  dmem_responder_byte_merge u_byte_merge (
    .old_word_i  (old_word),
    .new_word_i  (cur_wdata),
    .byte_mask_i (cur_mask),
    .merged_o    (merged_word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    in_range_d = in_range_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d       = bus.req_we;
          idx_d      = req_off[IdxW+1:2];
          wdata_d    = bus.req_wdata;
          mask_d     = bus.req_bytemask;
          in_range_d = req_in_range;
          cnt_d      = CntInit;
          state_d    = NoWait ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      rdata_d = (!cur_we && cur_in_range) ? old_word : 32'h0;
      err_d   = !cur_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'h0;
      mask_q     <= '0;
      in_range_q <= 1'b0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      in_range_q <= in_range_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= merged_word;
    end
  end

endmodule
